// File: rtl/xf100_ifu_fetch.sv
// In-order instruction fetch: PC sequencing, credit-limited bus requests, response FIFO toward EXU.
// Accept at N, response at N+k, instr_valid at N+k+1; requests stall while in-flight + buffered reaches DEPTH.
module xf100_ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ifu_o_req_valid,
    input  logic        ifu_i_req_ready,
    output logic [31:0] ifu_o_req_addr,
    input  logic        ifu_i_rsp_valid,
    input  logic [31:0] ifu_i_rsp_instr,
    input  logic        ifu_i_rsp_err,
    output logic        ifu_o_instr_valid,
    input  logic        exu_i_instr_ready,
    output logic [31:0] ifu_o_instr,
    output logic [31:0] ifu_o_pc,
    output logic        ifu_o_instr_err,
    input  logic        ifu_i_redirect,
    input  logic [31:0] ifu_i_redirect_pc
);

    localparam int          AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW  = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        err;
    } entry_t;

    entry_t          fifo_q [DEPTH];
    logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]   fifo_cnt_q, out_cnt_q, drop_cnt_q;
    logic [31:0]     pc_q, rsp_pc_q;

    logic [CW:0]     used;
    logic            req_fire, rsp_drop, push, pop;
    logic [31:0]     redirect_tgt;
    entry_t          head;
    logic            unused_redirect_lsb;

    assign redirect_tgt        = {ifu_i_redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsb = ^ifu_i_redirect_pc[1:0];

    // Conservative credit: a pop in the same cycle does not free a slot.
    assign used            = {1'b0, out_cnt_q} + {1'b0, fifo_cnt_q};
    assign ifu_o_req_valid = ~rst & ~ifu_i_redirect & (used < (CW+1)'(DEPTH));
    assign ifu_o_req_addr  = pc_q;
    assign req_fire        = ifu_o_req_valid & ifu_i_req_ready;

    assign rsp_drop = ifu_i_rsp_valid & (drop_cnt_q != '0);
    assign push     = ifu_i_rsp_valid & ~rsp_drop & ~ifu_i_redirect & ~rst;

    assign head              = fifo_q[rd_ptr_q];
    assign ifu_o_instr_valid = ~rst & (fifo_cnt_q != '0);
    assign pop               = ifu_o_instr_valid & exu_i_instr_ready;

    assign ifu_o_instr     = (ifu_o_instr_valid & ~head.err) ? head.instr : NOP;
    assign ifu_o_pc        = ifu_o_instr_valid ? head.pc : 32'h0;
    assign ifu_o_instr_err = ifu_o_instr_valid & head.err;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= '{instr: ifu_i_rsp_instr, pc: rsp_pc_q, err: ifu_i_rsp_err};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
            fifo_cnt_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            out_cnt_q <= out_cnt_q + CW'(req_fire) - CW'(ifu_i_rsp_valid);
            if (ifu_i_redirect) begin
                // Everything still on the bus after this edge belongs to the old stream.
                pc_q       <= redirect_tgt;
                rsp_pc_q   <= redirect_tgt;
                drop_cnt_q <= out_cnt_q - CW'(ifu_i_rsp_valid);
                fifo_cnt_q <= '0;
                rd_ptr_q   <= '0;
                wr_ptr_q   <= '0;
            end else begin
                if (req_fire) begin
                    pc_q <= pc_q + 32'd4;
                end
                if (rsp_drop) begin
                    drop_cnt_q <= drop_cnt_q - CW'(1);
                end
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                    rsp_pc_q <= rsp_pc_q + 32'd4;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                end
                fifo_cnt_q <= fifo_cnt_q + CW'(push) - CW'(pop);
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (push) begin
            assert (fifo_cnt_q != CW'(DEPTH) || pop);
        end
    end
`endif

endmodule

// File: tb/tb_xf100_ifu_fetch.sv
// Randomized bench for xf100_ifu_fetch: bus and EXU models plus an epoch-tagged scoreboard.
module tb_xf100_ifu_fetch;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        ifu_o_req_valid;
    logic        ifu_i_req_ready;
    logic [31:0] ifu_o_req_addr;
    logic        ifu_i_rsp_valid;
    logic [31:0] ifu_i_rsp_instr;
    logic        ifu_i_rsp_err;
    logic        ifu_o_instr_valid;
    logic        exu_i_instr_ready;
    logic [31:0] ifu_o_instr;
    logic [31:0] ifu_o_pc;
    logic        ifu_o_instr_err;
    logic        ifu_i_redirect;
    logic [31:0] ifu_i_redirect_pc;

    xf100_ifu_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk               (clk),
        .rst               (rst),
        .ifu_o_req_valid   (ifu_o_req_valid),
        .ifu_i_req_ready   (ifu_i_req_ready),
        .ifu_o_req_addr    (ifu_o_req_addr),
        .ifu_i_rsp_valid   (ifu_i_rsp_valid),
        .ifu_i_rsp_instr   (ifu_i_rsp_instr),
        .ifu_i_rsp_err     (ifu_i_rsp_err),
        .ifu_o_instr_valid (ifu_o_instr_valid),
        .exu_i_instr_ready (exu_i_instr_ready),
        .ifu_o_instr       (ifu_o_instr),
        .ifu_o_pc          (ifu_o_pc),
        .ifu_o_instr_err   (ifu_o_instr_err),
        .ifu_i_redirect    (ifu_i_redirect),
        .ifu_i_redirect_pc (ifu_i_redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
        logic        err;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
    } ent_t;

    req_t        pend[$];
    ent_t        mq[$];
    int          cyc, epoch, checks, errors;
    logic [31:0] exp_req_addr, exp_next_pc, last_pop_pc;
    int          p_req, p_exu, lat_min, lat_max, p_err;
    logic [31:0] err_addr;
    int          n_pops, n_fires;
    logic        saw_wrap;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a ^ 32'hA5C3_0F1E) * 32'h9E37_79B1 + 32'h1234_5678;
    endfunction

    // One clock cycle: drive, sample after settling, compare against the model, advance the model.
    task automatic step(input logic r, input logic redir, input logic [31:0] rpc);
        logic exp_rv, exp_iv, fire, pop, rspv, e_err;
        req_t e;
        ent_t h;
        int   due;
        @(negedge clk);
        rst               = r;
        ifu_i_redirect    = redir;
        ifu_i_redirect_pc = rpc;
        ifu_i_req_ready   = ($urandom_range(99) < p_req);
        exu_i_instr_ready = ($urandom_range(99) < p_exu);
        rspv = !r && pend.size() > 0 && pend[0].due <= cyc;
        ifu_i_rsp_valid = rspv;
        ifu_i_rsp_instr = rspv ? memf(pend[0].addr) : $urandom;
        ifu_i_rsp_err   = rspv ? pend[0].err : 1'b0;
        #1;
        exp_rv = !r && !redir && (pend.size() + mq.size() < DEPTH);
        exp_iv = !r && mq.size() > 0;
        checks++;
        if (ifu_o_req_valid !== exp_rv) begin
            errors++;
            $display("FAIL req_valid cyc=%0d: got %b exp %b", cyc, ifu_o_req_valid, exp_rv);
        end
        if (exp_rv) begin
            checks++;
            if (ifu_o_req_addr !== exp_req_addr) begin
                errors++;
                $display("FAIL req_addr cyc=%0d: got %h exp %h", cyc, ifu_o_req_addr, exp_req_addr);
            end
        end
        checks++;
        if (ifu_o_instr_valid !== exp_iv) begin
            errors++;
            $display("FAIL instr_valid cyc=%0d: got %b exp %b", cyc, ifu_o_instr_valid, exp_iv);
        end
        if (exp_iv) begin
            h = mq[0];
            checks++;
            if ({ifu_o_instr, ifu_o_pc, ifu_o_instr_err} !== {(h.err ? NOP : h.instr), h.pc, h.err}) begin
                errors++;
                $display("FAIL head cyc=%0d: got %h/%h/%b exp %h/%h/%b", cyc, ifu_o_instr, ifu_o_pc,
                         ifu_o_instr_err, (h.err ? NOP : h.instr), h.pc, h.err);
            end
        end else begin
            checks++;
            if ({ifu_o_instr, ifu_o_pc, ifu_o_instr_err} !== {NOP, 32'h0, 1'b0}) begin
                errors++;
                $display("FAIL idle_out cyc=%0d: got %h/%h/%b exp %h/0/0", cyc, ifu_o_instr, ifu_o_pc,
                         ifu_o_instr_err, NOP);
            end
        end

        if (r) begin
            pend.delete();
            mq.delete();
            exp_req_addr = RESET_PC;
            exp_next_pc  = RESET_PC;
        end else begin
            fire = exp_rv && ifu_i_req_ready;
            pop  = exp_iv && exu_i_instr_ready;
            if (pop) begin
                void'(mq.pop_front());
                checks++;
                if (ifu_o_pc !== exp_next_pc) begin
                    errors++;
                    $display("FAIL pc_seq cyc=%0d: got %h exp %h", cyc, ifu_o_pc, exp_next_pc);
                end
                if (ifu_o_pc == 32'h0 && n_pops > 0 && last_pop_pc == 32'hFFFF_FFFC) saw_wrap = 1'b1;
                last_pop_pc = ifu_o_pc;
                exp_next_pc = exp_next_pc + 32'd4;
                n_pops++;
            end
            if (rspv) begin
                e = pend.pop_front();
                if (e.epoch == epoch && !redir) mq.push_back('{e.addr, memf(e.addr), e.err});
            end
            if (redir) begin
                mq.delete();
                epoch++;
                exp_req_addr = {rpc[31:2], 2'b00};
                exp_next_pc  = {rpc[31:2], 2'b00};
            end
            if (fire) begin
                due = cyc + $urandom_range(lat_max, lat_min);
                if (pend.size() > 0 && due <= pend[$].due) due = pend[$].due + 1;
                e_err = (exp_req_addr == err_addr) || ($urandom_range(99) < p_err);
                pend.push_back('{exp_req_addr, due, epoch, e_err});
                exp_req_addr = exp_req_addr + 32'd4;
                n_fires++;
            end
        end
        cyc++;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'h0);
    endtask

    task automatic set_knobs(input int pr, input int pe, input int lmin, input int lmax, input int perr);
        p_req = pr; p_exu = pe; lat_min = lmin; lat_max = lmax; p_err = perr;
    endtask

    task automatic test_reset();
        set_knobs(100, 100, 1, 1, 0);
        do_reset(3);
        checks++;
        if (ifu_o_req_valid !== 1'b0 || ifu_o_instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valids: got %b/%b exp 0/0", ifu_o_req_valid, ifu_o_instr_valid);
        end
        p_req = 0;
        step(1'b0, 1'b0, 32'h0);
        checks++;
        if (ifu_o_req_valid !== 1'b1 || ifu_o_req_addr !== RESET_PC) begin
            errors++;
            $display("FAIL reset_first_req: got %b/%h exp 1/%h", ifu_o_req_valid, ifu_o_req_addr, RESET_PC);
        end
    endtask

    task automatic test_stream();
        int fire_cyc, valid_cyc, f, p0;
        logic [31:0] first_pc;
        fire_cyc = -1; valid_cyc = -1; first_pc = 32'h0;
        set_knobs(100, 100, 1, 1, 0);
        do_reset(2);
        p0 = n_pops;
        for (int i = 0; i < 40; i++) begin
            f = n_fires;
            step(1'b0, 1'b0, 32'h0);
            if (n_fires > f && fire_cyc < 0) fire_cyc = cyc - 1;
            if (ifu_o_instr_valid && valid_cyc < 0) begin
                valid_cyc = cyc - 1;
                first_pc  = ifu_o_pc;
            end
        end
        checks++;
        if (valid_cyc != fire_cyc + 2 || fire_cyc < 0) begin
            errors++;
            $display("FAIL stream_latency: got valid@%0d exp %0d", valid_cyc, fire_cyc + 2);
        end
        checks++;
        if (first_pc !== RESET_PC) begin
            errors++;
            $display("FAIL stream_first_pc: got %h exp %h", first_pc, RESET_PC);
        end
        checks++;
        if (n_pops - p0 < 15) begin
            errors++;
            $display("FAIL stream_throughput: got %0d pops exp >= 15", n_pops - p0);
        end
    endtask

    task automatic test_backpressure();
        int f0, p0;
        set_knobs(100, 0, 1, 1, 0);
        do_reset(2);
        f0 = n_fires;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0);
        checks++;
        if (n_fires - f0 != DEPTH || ifu_o_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_credit: got fires=%0d req_valid=%b exp %0d/0", n_fires - f0, ifu_o_req_valid, DEPTH);
        end
        checks++;
        if (ifu_o_instr_valid !== 1'b1 || ifu_o_pc !== RESET_PC) begin
            errors++;
            $display("FAIL bp_head: got %b/%h exp 1/%h", ifu_o_instr_valid, ifu_o_pc, RESET_PC);
        end
        p_exu = 100;
        p0 = n_pops;
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 32'h0);
        checks++;
        if (n_pops - p0 < 6) begin
            errors++;
            $display("FAIL bp_resume: got %0d pops exp >= 6", n_pops - p0);
        end
    endtask

    task automatic test_redirect();
        int n, p0;
        set_knobs(100, 100, 3, 3, 0);
        do_reset(2);
        n = 0;
        while (pend.size() != 2 && n < 10) begin
            step(1'b0, 1'b0, 32'h0);
            n++;
        end
        checks++;
        if (pend.size() != 2) begin
            errors++;
            $display("FAIL redir_setup: got %0d in flight exp 2", pend.size());
        end
        step(1'b0, 1'b1, 32'h0000_1002);
        checks++;
        if (ifu_o_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_no_req: got %b exp 0", ifu_o_req_valid);
        end
        n = 0;
        do begin
            step(1'b0, 1'b0, 32'h0);
            n++;
        end while (!ifu_o_req_valid && n < 10);
        checks++;
        if (ifu_o_req_valid !== 1'b1 || ifu_o_req_addr !== 32'h0000_1000) begin
            errors++;
            $display("FAIL redir_addr: got %b/%h exp 1/00001000", ifu_o_req_valid, ifu_o_req_addr);
        end
        p0 = n_pops;
        n = 0;
        while (n_pops == p0 && n < 20) begin
            step(1'b0, 1'b0, 32'h0);
            n++;
        end
        checks++;
        if (n_pops == p0 || last_pop_pc !== 32'h0000_1000) begin
            errors++;
            $display("FAIL redir_first_pc: got %h exp 00001000", last_pop_pc);
        end
    endtask

    task automatic test_err();
        logic seen_err, seen_next;
        int n;
        seen_err = 1'b0; seen_next = 1'b0;
        set_knobs(100, 100, 1, 1, 0);
        err_addr = 32'h8000_0008;
        do_reset(2);
        n = 0;
        while (!seen_next && n < 40) begin
            step(1'b0, 1'b0, 32'h0);
            n++;
            if (ifu_o_instr_valid && ifu_o_pc == 32'h8000_0008 && !seen_err) begin
                seen_err = 1'b1;
                checks++;
                if (ifu_o_instr !== NOP || ifu_o_instr_err !== 1'b1) begin
                    errors++;
                    $display("FAIL err_entry: got %h/%b exp %h/1", ifu_o_instr, ifu_o_instr_err, NOP);
                end
            end
            if (ifu_o_instr_valid && ifu_o_pc == 32'h8000_000C && !seen_next) begin
                seen_next = 1'b1;
                checks++;
                if (ifu_o_instr !== memf(32'h8000_000C) || ifu_o_instr_err !== 1'b0) begin
                    errors++;
                    $display("FAIL err_next: got %h/%b exp %h/0", ifu_o_instr, ifu_o_instr_err, memf(32'h8000_000C));
                end
            end
        end
        checks++;
        if (!seen_err || !seen_next) begin
            errors++;
            $display("FAIL err_seen: got %b/%b exp 1/1", seen_err, seen_next);
        end
        err_addr = 32'h0000_0001;
    endtask

    task automatic test_random();
        logic redir, prev_stall;
        logic [31:0] prev_addr;
        prev_stall = 1'b0; prev_addr = 32'h0;
        set_knobs(60, 70, 1, 3, 10);
        do_reset(2);
        for (int i = 0; i < 800; i++) begin
            redir = ($urandom_range(99) < 3);
            step(1'b0, redir, $urandom);
            if (prev_stall && !redir) begin
                checks++;
                if (ifu_o_req_valid !== 1'b1 || ifu_o_req_addr !== prev_addr) begin
                    errors++;
                    $display("FAIL req_stable: got %b/%h exp 1/%h", ifu_o_req_valid, ifu_o_req_addr, prev_addr);
                end
            end
            prev_stall = ifu_o_req_valid && !ifu_i_req_ready;
            prev_addr  = ifu_o_req_addr;
        end
        saw_wrap = 1'b0;
        step(1'b0, 1'b1, 32'hFFFF_FFF3);
        set_knobs(100, 100, 1, 3, 0);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 32'h0);
        checks++;
        if (saw_wrap !== 1'b1) begin
            errors++;
            $display("FAIL pc_wrap: got %b exp 1", saw_wrap);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        set_knobs(100, 0, 1, 1, 0);
        do_reset(2);
        n = 0;
        while (mq.size() != 2 && n < 20) begin
            step(1'b0, 1'b0, 32'h0);
            n++;
        end
        checks++;
        if (ifu_o_instr_valid !== 1'b1 || mq.size() != 2) begin
            errors++;
            $display("FAIL rstmid_setup: got valid=%b buffered=%0d exp 1/2", ifu_o_instr_valid, mq.size());
        end
        step(1'b1, 1'b0, 32'h0);
        checks++;
        if (ifu_o_instr_valid !== 1'b0 || ifu_o_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_outputs: got %b/%b exp 0/0", ifu_o_instr_valid, ifu_o_req_valid);
        end
        step(1'b1, 1'b0, 32'h0);
        p_exu = 100;
        step(1'b0, 1'b0, 32'h0);
        checks++;
        if (ifu_o_instr_valid !== 1'b0 || ifu_o_req_valid !== 1'b1 || ifu_o_req_addr !== RESET_PC) begin
            errors++;
            $display("FAIL rstmid_restart: got %b/%b/%h exp 0/1/%h", ifu_o_instr_valid, ifu_o_req_valid,
                     ifu_o_req_addr, RESET_PC);
        end
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        rst = 1'b1; ifu_i_req_ready = 1'b0; ifu_i_rsp_valid = 1'b0; ifu_i_rsp_instr = 32'h0;
        ifu_i_rsp_err = 1'b0; exu_i_instr_ready = 1'b0; ifu_i_redirect = 1'b0; ifu_i_redirect_pc = 32'h0;
        cyc = 0; epoch = 0; checks = 0; errors = 0; n_pops = 0; n_fires = 0;
        exp_req_addr = RESET_PC; exp_next_pc = RESET_PC; last_pop_pc = 32'h0;
        err_addr = 32'h0000_0001; saw_wrap = 1'b0;
        set_knobs(100, 100, 1, 1, 0);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_err();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
